// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator producing h/v counters, blanking,
// sync and line/frame strobes from CRTC-style programmable timing values.
// Optional build macro VIDEO_TIMING_SHADOW_EN double-buffers all timing inputs
// so that they update only at frame boundaries. Without it, inputs are used live.
module video_timing_gen #(
  parameter int unsigned W               = 9,
  parameter int unsigned HBL_DELAY       = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] htotal,
  input  logic [W-1:0] vtotal,
  input  logic [W-1:0] hbstart,
  input  logic [W-1:0] vbstart,
  input  logic [W-1:0] hsstart,
  input  logic [W-1:0] hsend,
  input  logic [W-1:0] vsstart,
  input  logic [W-1:0] vsend,
  input  logic [3:0]   hs_offset,
  input  logic [3:0]   vs_offset,
  output logic [W-1:0] hc,
  output logic [W-1:0] vc,
  output logic         hbl,
  output logic         vbl,
  output logic         hbl_dly,
  output logic         hsync,
  output logic         vsync,
  output logic         line_start,
  output logic         frame_start
);

  // Timing values as seen by the counters (c_*) and by the flag logic (f_*)
  logic [W-1:0] c_htotal, c_vtotal;
  logic [W-1:0] f_hbstart, f_vbstart, f_hsstart, f_hsend, f_vsstart, f_vsend;
  logic [3:0]   f_hs_off, f_vs_off;

  logic [W-1:0] hc_nxt, vc_nxt;
  logic         h_wrap;
  logic [W-1:0] hs0, hs1, vs0, vs1;

`ifdef VIDEO_TIMING_SHADOW_EN
  logic [W-1:0] s_htotal, s_vtotal, s_hbstart, s_vbstart;
  logic [W-1:0] s_hsstart, s_hsend, s_vsstart, s_vsend;
  logic [3:0]   s_hs_off, s_vs_off;
  logic         frame_wrap;

  assign frame_wrap = (hc_nxt == '0) && (vc_nxt == '0);

  // Shadow copies of the timing inputs, refreshed in reset and at frame wrap
  always_ff @(posedge clk) begin
    if (reset || frame_wrap) begin
      s_htotal  <= htotal;
      s_vtotal  <= vtotal;
      s_hbstart <= hbstart;
      s_vbstart <= vbstart;
      s_hsstart <= hsstart;
      s_hsend   <= hsend;
      s_vsstart <= vsstart;
      s_vsend   <= vsend;
      s_hs_off  <= hs_offset;
      s_vs_off  <= vs_offset;
    end
  end

  // Counters always run from the shadow copy. The flags registered on the wrap
  // edge describe cycle (0,0) of the new frame, so they use the values being
  // loaded on that same edge rather than the outgoing shadow copy.
  always_comb begin
    c_htotal  = s_htotal;
    c_vtotal  = s_vtotal;
    f_hbstart = frame_wrap ? hbstart   : s_hbstart;
    f_vbstart = frame_wrap ? vbstart   : s_vbstart;
    f_hsstart = frame_wrap ? hsstart   : s_hsstart;
    f_hsend   = frame_wrap ? hsend     : s_hsend;
    f_vsstart = frame_wrap ? vsstart   : s_vsstart;
    f_vsend   = frame_wrap ? vsend     : s_vsend;
    f_hs_off  = frame_wrap ? hs_offset : s_hs_off;
    f_vs_off  = frame_wrap ? vs_offset : s_vs_off;
  end
`else
  // Live timing inputs
  always_comb begin
    c_htotal  = htotal;
    c_vtotal  = vtotal;
    f_hbstart = hbstart;
    f_vbstart = vbstart;
    f_hsstart = hsstart;
    f_hsend   = hsend;
    f_vsstart = vsstart;
    f_vsend   = vsend;
    f_hs_off  = hs_offset;
    f_vs_off  = vs_offset;
  end
`endif

  // Half-open window [a, b) that wraps through zero when a > b; empty when a == b
  function automatic logic in_window(input logic [W-1:0] x, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (a < b)      return (x >= a) && (x < b);
    else if (a > b) return (x >= a) || (x < b);
    else            return 1'b0;
  endfunction

  // Next counter values and offset-adjusted sync windows
  always_comb begin
    h_wrap = (hc >= c_htotal);
    hc_nxt = h_wrap ? '0 : hc + W'(1);
    vc_nxt = vc;
    if (h_wrap) vc_nxt = (vc >= c_vtotal) ? '0 : vc + W'(1);
    hs0 = f_hsstart + {{(W-4){f_hs_off[3]}}, f_hs_off};
    hs1 = f_hsend   + {{(W-4){f_hs_off[3]}}, f_hs_off};
    vs0 = f_vsstart + {{(W-4){f_vs_off[3]}}, f_vs_off};
    vs1 = f_vsend   + {{(W-4){f_vs_off[3]}}, f_vs_off};
  end

  // Counters and flags, all registered from the next-state counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      hbl         <= 1'b0;
      vbl         <= 1'b0;
      hsync       <= SYNC_ACTIVE_LOW;
      vsync       <= SYNC_ACTIVE_LOW;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hbl         <= (hc_nxt >= f_hbstart);
      vbl         <= (vc_nxt >= f_vbstart);
      hsync       <= in_window(hc_nxt, hs0, hs1) ^ SYNC_ACTIVE_LOW;
      vsync       <= in_window(vc_nxt, vs0, vs1) ^ SYNC_ACTIVE_LOW;
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

  generate
    if (HBL_DELAY == 0) begin : g_no_dly
      assign hbl_dly = hbl;
    end else begin : g_dly
      logic [HBL_DELAY-1:0] dly;

      // Shift register delaying hbl by HBL_DELAY clocks
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dly <= '0;
        end else begin
          dly[0] <= hbl;
          for (int unsigned i = 1; i < HBL_DELAY; i++) dly[i] <= dly[i-1];
        end
      end

      assign hbl_dly = dly[HBL_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: three instances share all inputs
// (default parameters, HBL_DELAY=3 with active-high sync, HBL_DELAY=0).
// Vertical checks use a 16-clock line so a full frame fits a short run.
module tb_video_timing_gen;
  localparam int unsigned W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] htotal, vtotal, hbstart, vbstart, hsstart, hsend, vsstart, vsend;
  logic [3:0]   hs_offset, vs_offset;

  logic [W-1:0] hc0, vc0, hc3, vc3, hcz, vcz;
  logic hbl0, vbl0, hbd0, hs0, vs0, ls0, fs0;
  logic hbl3, vbl3, hbd3, hs3, vs3, ls3, fs3;
  logic hblz, vblz, hbdz, hsz, vsz, lsz, fsz;

  int n_checks = 0;
  int n_pass   = 0;

  int hbl_rise, hbl_cnt, hs_rise, hs_cnt, hs_at0, hbd0_rise, hbd3_rise, hbd3_cnt;
  int hs3_rise, hs3_cnt, dz_err, ls_cnt, fs_cnt, vbl_rise, vbl_cnt, vs_rise, vs_cnt;
  int seq_err;

  always #5 clk = ~clk;

  video_timing_gen #(.W(W), .HBL_DELAY(1), .SYNC_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .reset(reset), .htotal(htotal), .vtotal(vtotal), .hbstart(hbstart),
    .vbstart(vbstart), .hsstart(hsstart), .hsend(hsend), .vsstart(vsstart), .vsend(vsend),
    .hs_offset(hs_offset), .vs_offset(vs_offset), .hc(hc0), .vc(vc0), .hbl(hbl0),
    .vbl(vbl0), .hbl_dly(hbd0), .hsync(hs0), .vsync(vs0), .line_start(ls0),
    .frame_start(fs0));

  video_timing_gen #(.W(W), .HBL_DELAY(3), .SYNC_ACTIVE_LOW(1'b0)) dut3 (
    .clk(clk), .reset(reset), .htotal(htotal), .vtotal(vtotal), .hbstart(hbstart),
    .vbstart(vbstart), .hsstart(hsstart), .hsend(hsend), .vsstart(vsstart), .vsend(vsend),
    .hs_offset(hs_offset), .vs_offset(vs_offset), .hc(hc3), .vc(vc3), .hbl(hbl3),
    .vbl(vbl3), .hbl_dly(hbd3), .hsync(hs3), .vsync(vs3), .line_start(ls3),
    .frame_start(fs3));

  video_timing_gen #(.W(W), .HBL_DELAY(0), .SYNC_ACTIVE_LOW(1'b1)) dutz (
    .clk(clk), .reset(reset), .htotal(htotal), .vtotal(vtotal), .hbstart(hbstart),
    .vbstart(vbstart), .hsstart(hsstart), .hsend(hsend), .vsstart(vsstart), .vsend(vsend),
    .hs_offset(hs_offset), .vs_offset(vs_offset), .hc(hcz), .vc(vcz), .hbl(hblz),
    .vbl(vblz), .hbl_dly(hbdz), .hsync(hsz), .vsync(vsz), .line_start(lsz),
    .frame_start(fsz));

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic set_nominal();
    htotal = 9'd415; hbstart = 9'd320; hsstart = 9'd360; hsend = 9'd380;
    vtotal = 9'd261; vbstart = 9'd240; vsstart = 9'd250; vsend = 9'd253;
    hs_offset = 4'd0; vs_offset = 4'd0;
  endtask

  // Wait (at negedges) for hc == h (and vc == v when use_v), bounded
  task automatic wait_pos(input int h, input int v, input bit use_v, input int bound,
                          input string tag);
    int found = 0;
    for (int i = 0; i < bound; i++) begin
      if (int'(hc0) == h && (!use_v || int'(vc0) == v)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, found, 1);
  endtask

  task automatic wait_frame(input int bound, input string tag);
    int found = 0;
    for (int i = 0; i < bound; i++) begin
      if (fs0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, found, 1);
  endtask

  // Sample n cycles starting at hc = 0 (vc = 0 when track_v), recording first
  // rising position and active count for each flag against a reference raster
  task automatic scan(input int n, input int htot, input int vtot, input bit track_v);
    int eh = 0;
    int ev = 0;
    logic p_hbl, p_hs, p_hbd0, p_hbd3, p_hs3, p_vbl, p_vs;
    hbl_rise = -1; hbl_cnt = 0; hs_rise = -1; hs_cnt = 0; hbd0_rise = -1;
    hbd3_rise = -1; hbd3_cnt = 0; hs3_rise = -1; hs3_cnt = 0; dz_err = 0;
    ls_cnt = 0; fs_cnt = 0; vbl_rise = -1; vbl_cnt = 0; vs_rise = -1; vs_cnt = 0;
    seq_err = 0;
    hs_at0 = int'(!hs0);
    p_hbl = hbl0; p_hs = !hs0; p_hbd0 = hbd0; p_hbd3 = hbd3; p_hs3 = hs3;
    p_vbl = vbl0; p_vs = !vs0;
    for (int i = 0; i < n; i++) begin
      if (int'(hc0) != eh) seq_err++;
      if (track_v && int'(vc0) != ev) seq_err++;
      if (hbl0) hbl_cnt++;
      if (hbl0 && !p_hbl && hbl_rise < 0) hbl_rise = eh;
      if (!hs0) hs_cnt++;
      if (!hs0 && !p_hs && hs_rise < 0) hs_rise = eh;
      if (hbd0 && !p_hbd0 && hbd0_rise < 0) hbd0_rise = eh;
      if (hbd3) hbd3_cnt++;
      if (hbd3 && !p_hbd3 && hbd3_rise < 0) hbd3_rise = eh;
      if (hs3) hs3_cnt++;
      if (hs3 && !p_hs3 && hs3_rise < 0) hs3_rise = eh;
      if (hbdz != hblz) dz_err++;
      if (ls0) ls_cnt++;
      if (fs0) fs_cnt++;
      if (vbl0) vbl_cnt++;
      if (vbl0 && !p_vbl && vbl_rise < 0) vbl_rise = ev;
      if (!vs0) vs_cnt++;
      if (!vs0 && !p_vs && vs_rise < 0) vs_rise = ev;
      p_hbl = hbl0; p_hs = !hs0; p_hbd0 = hbd0; p_hbd3 = hbd3; p_hs3 = hs3;
      p_vbl = vbl0; p_vs = !vs0;
      if (eh >= htot) begin
        eh = 0;
        ev = (ev >= vtot) ? 0 : ev + 1;
      end else begin
        eh++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_nominal();
    @(negedge clk);
    @(negedge clk);
    check("rst hc", int'(hc0), 0);
    check("rst vc", int'(vc0), 0);
    check("rst hbl", int'(hbl0), 0);
    check("rst vbl", int'(vbl0), 0);
    check("rst hsync lo-act", int'(hs0), 1);
    check("rst vsync lo-act", int'(vs0), 1);
    check("rst hsync hi-act", int'(hs3), 0);
    check("rst line_start", int'(ls0), 0);
    check("rst frame_start", int'(fs0), 0);
    check("rst hbl_dly3", int'(hbd3), 0);

    reset = 1'b0;
    @(negedge clk);
    check("first hc", int'(hc0), 1);
    check("first vc", int'(vc0), 0);
    check("first hbl", int'(hbl0), 0);
    check("first frame_start", int'(fs0), 0);

    // Nominal horizontal line
    wait_pos(0, 0, 1'b0, 1000, "wait line nominal");
    scan(416, 415, 261, 1'b0);
    check("nom hbl rise", hbl_rise, 320);
    check("nom hbl cnt", hbl_cnt, 96);
    check("nom hsync rise", hs_rise, 360);
    check("nom hsync cnt", hs_cnt, 20);
    check("nom hbl_dly1 rise", hbd0_rise, 321);
    check("nom hbl_dly3 rise", hbd3_rise, 323);
    check("nom hbl_dly3 cnt", hbd3_cnt, 96);
    check("pos hsync rise", hs3_rise, 360);
    check("pos hsync cnt", hs3_cnt, 20);
    check("dly0 vs hbl", dz_err, 0);
    check("nom line_start cnt", ls_cnt, 1);
    check("nom frame_start cnt", fs_cnt, 0);
    check("nom hc seq", seq_err, 0);
    check("nom line len", int'(hc0), 0);
    check("nom hbl fall", int'(hbl0), 0);

    // hs_offset = -4
    hs_offset = 4'hC;
    @(negedge clk);
    wait_pos(0, 0, 1'b0, 1000, "wait line offset");
    scan(416, 415, 261, 1'b0);
    check("off hsync rise", hs_rise, 356);
    check("off hsync cnt", hs_cnt, 20);
    check("off pos hsync rise", hs3_rise, 356);

    // Window wrapping through zero
    hs_offset = 4'd0; hsstart = 9'd410; hsend = 9'd5;
    @(negedge clk);
    wait_pos(0, 0, 1'b0, 1000, "wait line wrap");
    scan(416, 415, 261, 1'b0);
    check("wrap hsync rise", hs_rise, 410);
    check("wrap hsync cnt", hs_cnt, 11);
    check("wrap hsync at 0", hs_at0, 1);

    // Empty window
    hsstart = 9'd100; hsend = 9'd100;
    @(negedge clk);
    wait_pos(0, 0, 1'b0, 1000, "wait line empty");
    scan(416, 415, 261, 1'b0);
    check("empty hsync cnt", hs_cnt, 0);

    // Lowering htotal below the current hc
    set_nominal();
    wait_pos(405, 0, 1'b0, 1000, "wait hc 405");
    htotal = 9'd399;
    @(negedge clk);
`ifdef VIDEO_TIMING_SHADOW_EN
    check("htotal drop deferred", int'(hc0), 406);
`else
    check("htotal drop wrap", int'(hc0), 0);
    check("htotal drop line_start", int'(ls0), 1);
    scan(400, 399, 261, 1'b0);
    check("short hc seq", seq_err, 0);
    check("short line len", int'(hc0), 0);
`endif

    // Vertical checks with 16-clock lines, 262-line frame
    htotal = 9'd15; hbstart = 9'd12; hsstart = 9'd13; hsend = 9'd14;
    wait_frame(6000, "wait frame v");
    scan(4192, 15, 261, 1'b1);
    check("v vbl rise", vbl_rise, 240);
    check("v vbl cnt", vbl_cnt, 352);
    check("v vsync rise", vs_rise, 250);
    check("v vsync cnt", vs_cnt, 48);
    check("v frame_start cnt", fs_cnt, 1);
    check("v line_start cnt", ls_cnt, 262);
    check("v hc/vc seq", seq_err, 0);
    check("v frame period", int'(fs0), 1);

    // vs_offset = +2
    vs_offset = 4'd2;
    @(negedge clk);
    wait_frame(6000, "wait frame voff");
    scan(4192, 15, 261, 1'b1);
    check("voff vsync rise", vs_rise, 252);
    check("voff vsync cnt", vs_cnt, 48);

    // htotal = 0, vbstart beyond vtotal, hbstart beyond htotal
    vs_offset = 4'd0; htotal = 9'd0; vtotal = 9'd5; vbstart = 9'd300;
    @(negedge clk);
    wait_frame(100, "wait frame degen");
    scan(12, 0, 5, 1'b1);
    check("degen line_start cnt", ls_cnt, 12);
    check("degen frame_start cnt", fs_cnt, 2);
    check("degen vbl cnt", vbl_cnt, 0);
    check("degen hbl cnt", hbl_cnt, 0);
    check("degen vc seq", seq_err, 0);

    // Asynchronous reset in mid-frame
    set_nominal();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_pos(200, 100, 1'b1, 45000, "wait hc200 vc100");
    #2 reset = 1'b1;
    #1;
    check("arst hc", int'(hc0), 0);
    check("arst vc", int'(vc0), 0);
    check("arst hbl", int'(hbl0), 0);
    check("arst vbl", int'(vbl0), 0);
    check("arst hsync lo-act", int'(hs0), 1);
    check("arst vsync lo-act", int'(vs0), 1);
    check("arst hsync hi-act", int'(hs3), 0);
    check("arst line_start", int'(ls0), 0);
    check("arst frame_start", int'(fs0), 0);
    check("arst hbl_dly3", int'(hbd3), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("post-rst hc", int'(hc0), k);
      check("post-rst vc", int'(vc0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
